// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster counters, pixel strobe and registered sync-aligned VGA DAC outputs
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       pix_en,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic [DW-1:0] div, div_nxt;
  logic          h_wrap, v_wrap, vis;
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
    h_wrap  = h_counter == H_LAST;
    v_wrap  = v_counter == V_LAST;
    vis     = (h_counter < H_VIS) && (v_counter < V_VIS);
  end
  assign VGA_SYNC_N = 1'b0;
  // pix_en is a flop timed to be high exactly while div sits at its last count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div         <= '0;
      pix_en      <= 1'b0;
      VGA_CLK     <= 1'b0;
      frame_start <= 1'b0;
      h_counter   <= '0;
      v_counter   <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      div         <= div_nxt;
      pix_en      <= div == DIV_PRE;
      VGA_CLK     <= div_nxt >= DIV_HALF;
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        h_counter   <= h_wrap ? '0 : h_counter + 10'd1;
        v_counter   <= !h_wrap ? v_counter : v_wrap ? '0 : v_counter + 10'd1;
        VGA_R       <= vis ? R_in : '0;
        VGA_G       <= vis ? G_in : '0;
        VGA_B       <= vis ? B_in : '0;
        VGA_BLANK_N <= vis;
        VGA_HS      <= !((h_counter >= HS_BEG) && (h_counter <= HS_END));
        VGA_VS      <= !((v_counter >= VS_BEG) && (v_counter <= VS_END));
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA raster on a full-size instance and a shrunken CLK_DIV=4 instance
module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [9:0] h0, v0, h1, v1;
  logic       pe0, fs0, vc0, hs0, vs0, bn0, sn0;
  logic       pe1, fs1, vc1, hs1, vs1, bn1, sn1;
  logic [7:0] ro0, go0, bo0, ro1, go1, bo1;
  int         tests = 0;
  int         fails = 0;
  int         n;
  always #5 clk = ~clk;
  vga_timing_gen u0 (
    .clk(clk), .reset(rst0), .R_in(r0), .G_in(g0), .B_in(b0),
    .h_counter(h0), .v_counter(v0), .pix_en(pe0), .frame_start(fs0),
    .VGA_CLK(vc0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0),
    .VGA_R(ro0), .VGA_G(go0), .VGA_B(bo0)
  );
  // 16x8 raster (visible 8x4, hsync h=10..12, vsync v=5..6), 4 clk per pixel
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(4)
  ) u1 (
    .clk(clk), .reset(rst1), .R_in(r1), .G_in(g1), .B_in(b1),
    .h_counter(h1), .v_counter(v1), .pix_en(pe1), .frame_start(fs1),
    .VGA_CLK(vc1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1),
    .VGA_R(ro1), .VGA_G(go1), .VGA_B(bo1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_hv(input logic [9:0] h, input logic [9:0] v, input int budget);
    int c = 0;
    while (!(h0 == h && v0 == v && pe0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_hv", 32'(c < budget), 32'd1);
  endtask
  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    r0 = 8'h00; g0 = 8'h00; b0 = 8'h00;
    r1 = 8'h12; g1 = 8'h34; b1 = 8'h56;
    repeat (2) @(negedge clk);
    chk("rst_h", h0, 0);
    chk("rst_v", v0, 0);
    chk("rst_pix_en", pe0, 0);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_blank_n", bn0, 0);
    chk("rst_r", ro0, 0);
    chk("rst_vga_clk", vc0, 0);
    chk("rst_frame_start", fs0, 0);
    chk("sync_n", sn0, 0);
    rst0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("start_pix_en", pe0, 32'(k % 2));
      chk("start_h", h0, 32'(k / 2));
      chk("start_vga_clk", vc0, 32'(k % 2));
      chk("start_blank_n", bn0, 32'(k >= 2));
      chk("start_frame_start", fs0, 0);
      @(negedge clk);
    end
    wait_hv(10'd10, 10'd5, 20000);
    r0 = 8'hAA; g0 = 8'h55; b0 = 8'h3C;
    @(negedge clk);
    chk("vis_h", h0, 11);
    chk("vis_r", ro0, 8'hAA);
    chk("vis_g", go0, 8'h55);
    chk("vis_b", bo0, 8'h3C);
    chk("vis_blank_n", bn0, 1);
    r0 = 8'hFF; g0 = 8'hFF; b0 = 8'hFF;
    wait_hv(10'd700, 10'd5, 2000);
    @(negedge clk);
    chk("blank_r", ro0, 0);
    chk("blank_g", go0, 0);
    chk("blank_blank_n", bn0, 0);
    chk("blank_hs", hs0, 0);
    wait_hv(10'd656, 10'd6, 4000);
    chk("hs_before", hs0, 1);
    @(negedge clk);
    chk("hs_fall", hs0, 0);
    chk("hs_fall_h", h0, 657);
    n = 0;
    while (hs0 === 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hs_low_clk", n, 192);
    chk("hs_rise_h", h0, 753);
    while (hs0 === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("line_clk", n, 1600);
    chk("line_next_h", h0, 657);
    chk("line_next_v", v0, 7);
    wait_hv(10'd400, 10'd8, 3000);
    chk("pre_rst_vga_clk", vc0, 1);
    chk("pre_rst_r", ro0, 8'hFF);
    chk("pre_rst_blank_n", bn0, 1);
    #2 rst0 = 1'b0;
    #1;
    chk("arst_h", h0, 0);
    chk("arst_v", v0, 0);
    chk("arst_pix_en", pe0, 0);
    chk("arst_vga_clk", vc0, 0);
    chk("arst_r", ro0, 0);
    chk("arst_blank_n", bn0, 0);
    chk("arst_hs", hs0, 1);
    chk("arst_vs", vs0, 1);
    @(negedge clk);
    chk("arst_hold_h", h0, 0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("restart_pix_en", pe0, 1);
    chk("restart_h0", h0, 0);
    @(negedge clk);
    chk("restart_h1", h0, 1);
    chk("restart_v", v0, 0);
    chk("restart_blank_n", bn0, 1);
    chk("restart_r", ro0, 8'hFF);
    rst1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("div4_pix_en", pe1, 32'(k % 4 == 3));
      chk("div4_vga_clk", vc1, 32'(k % 4 >= 2));
      chk("div4_h", h1, 32'(k / 4));
      @(negedge clk);
    end
    n = 0;
    while (vs1 === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("vs_fall", vs1, 0);
    chk("vs_fall_h", h1, 1);
    chk("vs_fall_v", v1, 5);
    n = 0;
    while (vs1 === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("vs_low_clk", n, 128);
    chk("vs_rise_v", v1, 7);
    n = 0;
    while (fs1 === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("fs_first", fs1, 1);
    chk("fs_h", h1, 0);
    chk("fs_v", v1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("fs_width", fs1, 0);
    end while (fs1 === 1'b0 && n < 2000);
    chk("fs_period_clk", n, 512);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
